// File: rtl/y_signature_misr_pkg.sv
// Shared definitions for the y-bus signature compactor.
//   state_e    : controller states
//   nchunk()   : number of 32-bit chunks covering a bus of a given width
//   misr_step(): one MISR fold of a 32-bit chunk into the signature
package misr_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ARMED = 2'd1,
    FOLD  = 2'd2,
    DONE  = 2'd3
  } state_e;

  localparam int          SIG_W        = 32;
  localparam logic [31:0] POLY_DEFAULT = 32'h04C11DB7;
  localparam logic [31:0] SEED_DEFAULT = 32'hFFFFFFFF;

  function automatic int nchunk(input int y_width);
    return (y_width + SIG_W - 1) / SIG_W;
  endfunction

  // Shift left, apply the feedback taps when the bit shifted out is set,
  // then mix in the chunk. Pure XOR, no carries.
  function automatic logic [31:0] misr_step(input logic [31:0] sig,
                                            input logic [31:0] chunk,
                                            input logic [31:0] poly = POLY_DEFAULT);
    return {sig[30:0], 1'b0} ^ (sig[31] ? poly : 32'h0) ^ chunk;
  endfunction

endpackage

// File: rtl/y_signature_misr_step_32.sv
// Combinational single fold step of the 32-bit MISR.
//   sig_i   : current signature
//   chunk_i : 32-bit data chunk to fold in
//   sig_o   : next signature
module misr_step_32
  import misr_pkg::*;
#(
  parameter logic [31:0] POLY = POLY_DEFAULT
) (
  input  logic [31:0] sig_i,
  input  logic [31:0] chunk_i,
  output logic [31:0] sig_o
);

  assign sig_o = misr_step(sig_i, chunk_i, POLY);

endmodule

// File: rtl/y_signature_misr.sv
// Compacts WINDOW accepted samples of a wide bus y into a 32-bit MISR
// signature, folding one 32-bit chunk per clock (chunk 0 first).
//   clk, rst_n        : clock, async active-low reset
//   start             : load SEED, clear count, arm capture (any state)
//   y_valid, y        : sample handshake / data in
//   y_ready           : high in ARMED only
//   busy              : high from start until the window completes
//   sample_cnt        : samples fully folded in the current window
//   sig_valid         : signature final, held until sig_ack
//   signature         : current MISR value
//   sig_ack           : consumer took signature
module y_signature_misr
  import misr_pkg::*;
#(
  parameter int          Y_WIDTH   = 550,
  parameter int          SIG_WIDTH = 32,
  parameter logic [31:0] POLY      = POLY_DEFAULT,
  parameter logic [31:0] SEED      = SEED_DEFAULT,
  parameter int          WINDOW    = 21
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic                 y_valid,
  input  logic [Y_WIDTH-1:0]   y,
  output logic                 y_ready,
  output logic                 busy,
  output logic [7:0]           sample_cnt,
  output logic                 sig_valid,
  output logic [SIG_WIDTH-1:0] signature,
  input  logic                 sig_ack
);

  localparam int NCHUNK = nchunk(Y_WIDTH);
  localparam int PAD_W  = NCHUNK * 32;

  state_e             state_q, state_d;
  logic [Y_WIDTH-1:0] hold_q, hold_d;
  logic [4:0]         idx_q, idx_d;
  logic [7:0]         cnt_q, cnt_d;
  logic [31:0]        sig_q, sig_d;
  logic               busy_q, busy_d;
  logic               sv_q, sv_d;

  logic [PAD_W-1:0]   hold_pad;
  logic [31:0]        chunk;
  logic [31:0]        sig_step;
  logic               last_chunk;

  // Top chunk is zero-padded above Y_WIDTH-1.
  assign hold_pad   = PAD_W'(hold_q);
  assign chunk      = hold_pad[{idx_q, 5'd0} +: 32];
  assign last_chunk = (idx_q == 5'(NCHUNK - 1));

  misr_step_32 #(.POLY(POLY)) u_step (
    .sig_i   (sig_q),
    .chunk_i (chunk),
    .sig_o   (sig_step)
  );

  always_comb begin
    state_d = state_q;
    hold_d  = hold_q;
    idx_d   = idx_q;
    cnt_d   = cnt_q;
    sig_d   = sig_q;
    busy_d  = busy_q;
    sv_d    = sv_q;

    // start aborts any window in progress and wins over sig_ack
    if (start) begin
      state_d = ARMED;
      sig_d   = SEED;
      cnt_d   = 8'd0;
      idx_d   = 5'd0;
      busy_d  = 1'b1;
      sv_d    = 1'b0;
    end else begin
      case (state_q)
        ARMED: begin
          if (y_valid) begin
            hold_d  = y;
            idx_d   = 5'd0;
            state_d = FOLD;
          end
        end
        FOLD: begin
          sig_d = sig_step;
          if (last_chunk) begin
            idx_d = 5'd0;
            cnt_d = cnt_q + 8'd1;
            if (cnt_q + 8'd1 == 8'(WINDOW)) begin
              state_d = DONE;
              busy_d  = 1'b0;
              sv_d    = 1'b1;
            end else begin
              state_d = ARMED;
            end
          end else begin
            idx_d = idx_q + 5'd1;
          end
        end
        DONE: begin
          if (sig_ack) begin
            state_d = IDLE;
            sv_d    = 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      hold_q  <= '0;
      idx_q   <= 5'd0;
      cnt_q   <= 8'd0;
      sig_q   <= SEED;
      busy_q  <= 1'b0;
      sv_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      hold_q  <= hold_d;
      idx_q   <= idx_d;
      cnt_q   <= cnt_d;
      sig_q   <= sig_d;
      busy_q  <= busy_d;
      sv_q    <= sv_d;
    end
  end

  assign y_ready    = (state_q == ARMED);
  assign busy       = busy_q;
  assign sample_cnt = cnt_q;
  assign sig_valid  = sv_q;
  assign signature  = SIG_WIDTH'(sig_q);

endmodule
